// File: rtl/mem_master_pkg.sv
// Shared types and constants for the Avalon memory master: access size,
// FSM state encoding, byteenable base patterns and small decode helpers.
package mem_master_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Raw size code 3 is folded onto word.
  function automatic size_e decode_size(input logic [1:0] raw);
    size_e result;
    case (raw)
      2'd0:    result = SZ_BYTE;
      2'd1:    result = SZ_HALF;
      default: result = SZ_WORD;
    endcase
    return result;
  endfunction

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for a little-endian 32-bit bus: byteenable generation,
// store-data replication and load-data extraction with sign/zero extension.
// Purely combinational; low address bits that do not fit the size are ignored.
module mem_lane_align
  import mem_master_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = rdata_in[{addr_lo, 3'b000} +: 8];
  assign lane_half = rdata_in[{addr_lo[1], 4'b0000} +: 16];

  // Select lanes and extend according to the access size.
  always_comb begin
    byteenable = BE_WORD;
    wdata_out  = wdata_in;
    rdata_out  = rdata_in;
    case (size)
      SZ_BYTE: begin
        byteenable = BE_BYTE << addr_lo;
        wdata_out  = {4{wdata_in[7:0]}};
        rdata_out  = {{24{is_signed & lane_byte[7]}}, lane_byte};
      end
      SZ_HALF: begin
        byteenable = BE_HALF << {addr_lo[1], 1'b0};
        wdata_out  = {2{wdata_in[15:0]}};
        rdata_out  = {{16{is_signed & lane_half[15]}}, lane_half};
      end
      default: begin
        byteenable = BE_WORD;
        wdata_out  = wdata_in;
        rdata_out  = rdata_in;
      end
    endcase
  end

endmodule

// File: rtl/avalon_mem_master.sv
// Multi-port Avalon-MM master: fixed-priority arbitration (port 0 highest),
// one outstanding transfer, waitrequest handshake and bus timeout.
// Optional MEM_MASTER_ALIGN_CHECK_EN: misaligned half/word accesses are
// answered with resp_err one cycle after acceptance without a bus cycle.
module avalon_mem_master
  import mem_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [2*NUM_PORTS-1:0]      req_size,
  input  logic [NUM_PORTS-1:0]        req_signed,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*32-1:0]     req_wdata,
  output logic [NUM_PORTS-1:0]        resp_valid,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_err,
  output logic                        busy,
  output logic [31:0]                 address,
  output logic                        write,
  output logic                        read,
  output logic [31:0]                 writedata,
  output logic [3:0]                  byteenable,
  input  logic                        waitrequest,
  input  logic [31:0]                 readdata
);

  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CNT_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e state_reg, state_next;

  logic [PORT_W-1:0] port_reg;
  logic [31:0]       addr_reg;
  size_e             size_reg;
  logic              signed_reg;
  logic              write_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;

  logic [ADDR_W-1:0] port_addr  [NUM_PORTS];
  logic [31:0]       port_wdata [NUM_PORTS];
  logic [1:0]        port_size  [NUM_PORTS];

  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    sel_idx;
  logic                 any_valid;
  logic [31:0]          sel_addr;
  size_e                sel_size;
  logic                 misaligned;
  logic                 timeout_hit;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  // Per-port views of the flattened request buses and per-port response pulse.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign port_wdata[gi] = req_wdata[gi*32 +: 32];
      assign port_size[gi]  = req_size[gi*2 +: 2];
      assign resp_valid[gi] = (state_reg == ST_RESP) && (port_reg == PORT_W'(gi));
    end
  endgenerate

  // Fixed priority: the lowest-index valid port wins.
  always_comb begin
    grant     = '0;
    sel_idx   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid[i] && !any_valid) begin
        grant[i]  = 1'b1;
        sel_idx   = PORT_W'(i);
        any_valid = 1'b1;
      end
    end
  end

  assign sel_addr  = 32'(port_addr[sel_idx]);
  assign sel_size  = decode_size(port_size[sel_idx]);
  assign req_ready = (state_reg == ST_IDLE) ? grant : '0;

`ifdef MEM_MASTER_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(sel_size, sel_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Abort on the N-th consecutive waitrequest cycle unless the slave answers.
  assign timeout_hit = TIMEOUT_EN && waitrequest && (wait_cnt_reg == CNT_LAST);

  // Steering works from the latched request so bus outputs stay stable.
  mem_lane_align u_lane_align (
    .size       (size_reg),
    .addr_lo    (addr_reg[1:0]),
    .is_signed  (signed_reg),
    .wdata_in   (wdata_reg),
    .rdata_in   (readdata),
    .byteenable (lane_be),
    .wdata_out  (lane_wdata),
    .rdata_out  (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_valid) state_next = misaligned ? ST_RESP : ST_BUS;
      ST_BUS:  if (!waitrequest || timeout_hit) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counting and response data/status capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_reg     <= '0;
      addr_reg     <= '0;
      size_reg     <= SZ_BYTE;
      signed_reg   <= 1'b0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      err_reg      <= 1'b0;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (any_valid) begin
          port_reg     <= sel_idx;
          addr_reg     <= sel_addr;
          size_reg     <= sel_size;
          signed_reg   <= req_signed[sel_idx];
          write_reg    <= req_write[sel_idx];
          wdata_reg    <= port_wdata[sel_idx];
          rdata_reg    <= '0;
          err_reg      <= misaligned;
          wait_cnt_reg <= '0;
        end
        ST_BUS: begin
          if (!waitrequest) begin
            rdata_reg <= write_reg ? 32'd0 : lane_rdata;
          end else if (timeout_hit) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != ST_IDLE);
  assign read       = (state_reg == ST_BUS) && !write_reg;
  assign write      = (state_reg == ST_BUS) && write_reg;
  assign address    = {addr_reg[31:2], 2'b00};
  assign writedata  = lane_wdata;
  assign byteenable = (state_reg == ST_BUS) ? lane_be : 4'b0000;
  assign resp_rdata = (state_reg == ST_RESP) ? rdata_reg : 32'd0;
  assign resp_err   = (state_reg == ST_RESP) && err_reg;

endmodule

// File: tb/tb_avalon_mem_master.sv
// Self-checking bench for avalon_mem_master (TIMEOUT_CYCLES = 4).
// Expected bus and response values come from an arithmetic reference model.
module tb_avalon_mem_master;

  localparam int TO = 4;
`ifdef MEM_MASTER_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = '0;
  logic [3:0]  req_size = '0;
  logic [1:0]  req_signed = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_mem_master #(.ADDR_W(32), .NUM_PORTS(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .address(address), .write(write),
    .read(read), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    n = nbytes(sz);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    n = nbytes(sz);
    return 4'(((1 << n) - 1) << lane_off(sz, addr));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    int n;
    longint piece;
    n = nbytes(sz);
    if (n == 4) return wd;
    piece = longint'(wd) % (longint'(1) << (8 * n));
    return 32'(piece * ((n == 1) ? 64'h01010101 : 64'h00010001));
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] sz, input logic sgn,
                                            input logic [31:0] addr, input logic [31:0] rd);
    int n;
    longint lim, v;
    n = nbytes(sz);
    if (n == 4) return rd;
    lim = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * lane_off(sz, addr))) % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] addr);
    int n;
    n = nbytes(sz);
    return ALIGN_CHK && (int'(addr % 4) % n != 0);
  endfunction

  // ---------------- single-port transaction driver ----------------
  task automatic run_txn(input int port, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, input string tag);
    logic mis, abort;
    int nbus, lat;
    logic [31:0] want_rd;
    mis     = exp_mis(sz, addr);
    abort   = !mis && (waits >= TO);
    nbus    = mis ? 0 : (abort ? TO : waits + 1);
    want_rd = (wr || mis || abort) ? 32'd0 : exp_rdata(sz, sgn, addr, rd);
    lat     = nbus + 1;

    @(negedge clk);
    req_write[port]          = wr;
    req_size[port*2 +: 2]    = sz;
    req_signed[port]         = sgn;
    req_addr[port*32 +: 32]  = addr;
    req_wdata[port*32 +: 32] = wd;
    req_valid                = '0;
    req_valid[port]          = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'(1 << port)) begin
      errors++;
      $display("FAIL %s req_ready: got %b want %b", tag, req_ready, 2'(1 << port));
    end
    @(negedge clk);
    req_valid = '0;

    for (int k = 0; k < nbus; k++) begin
      waitrequest = (k < waits);
      readdata    = waitrequest ? $urandom : rd;
      #1;
      checks++;
      if (read !== !wr || write !== wr) begin
        errors++;
        $display("FAIL %s bus_cycle%0d rd/wr: got %b/%b want %b/%b", tag, k, read, write, !wr, wr);
      end
      checks++;
      if (address !== (addr - (addr % 4))) begin
        errors++;
        $display("FAIL %s bus_cycle%0d address: got %h want %h", tag, k, address, addr - (addr % 4));
      end
      checks++;
      if (byteenable !== exp_be(sz, addr)) begin
        errors++;
        $display("FAIL %s bus_cycle%0d byteenable: got %b want %b", tag, k, byteenable, exp_be(sz, addr));
      end
      if (wr) begin
        checks++;
        if (writedata !== exp_wdata(sz, wd)) begin
          errors++;
          $display("FAIL %s bus_cycle%0d writedata: got %h want %h", tag, k, writedata, exp_wdata(sz, wd));
        end
      end
      checks++;
      if (resp_valid !== 2'b00 || req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s bus_cycle%0d idle_sigs: resp_valid=%b req_ready=%b busy=%b want 00/00/1",
                 tag, k, resp_valid, req_ready, busy);
      end
      @(negedge clk);
    end
    waitrequest = 1'b0;
    readdata    = $urandom;
    #1;
    checks++;
    if (resp_valid !== 2'(1 << port)) begin
      errors++;
      $display("FAIL %s resp_valid at T+%0d: got %b want %b", tag, lat, resp_valid, 2'(1 << port));
    end
    checks++;
    if (resp_rdata !== want_rd || resp_err !== (mis || abort)) begin
      errors++;
      $display("FAIL %s resp: rdata=%h err=%b want rdata=%h err=%b", tag, resp_rdata, resp_err, want_rd, mis || abort);
    end
    checks++;
    if (read !== 1'b0 || write !== 1'b0 || byteenable !== 4'b0000) begin
      errors++;
      $display("FAIL %s resp_bus_quiet: read=%b write=%b be=%b want 0/0/0000", tag, read, write, byteenable);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 2'b00) begin
      errors++;
      $display("FAIL %s back_to_idle: busy=%b resp_valid=%b want 0/00", tag, busy, resp_valid);
    end
    $display("txn %s port=%0d wr=%b size=%0d sgn=%b addr=%h waits=%0d rdata=%h err=%b",
             tag, port, wr, sz, sgn, addr, waits, want_rd, mis || abort);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, busy, address, write, read, writedata, byteenable} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b rdata=%h err=%b busy=%b addr=%h w=%b r=%b wd=%h be=%b want all 0",
               req_ready, resp_valid, resp_rdata, resp_err, busy, address, write, read, writedata, byteenable);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b req_ready=%b want 0/00", busy, req_ready);
    end
    $display("txn reset done");
  endtask

  task automatic test_word_load();
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "word_load");
  endtask

  task automatic test_byte_load();
    run_txn(1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, "byte_load_signed");
    run_txn(1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, "byte_load_unsigned");
    run_txn(0, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h9ABC1234, 1, "half_load_signed");
  endtask

  task automatic test_half_store_wait();
    run_txn(1, 1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 3, "half_store_wait3");
    run_txn(0, 1'b1, 2'd0, 1'b0, 32'h301, 32'hFFFFFF5A, 32'h0, 0, "byte_store");
    run_txn(0, 1'b1, 2'd3, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0, 1, "size3_store");
  endtask

  task automatic test_timeout();
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h11111111, 8, "timeout_read");
    run_txn(1, 1'b1, 2'd2, 1'b0, 32'h504, 32'h22222222, 32'h0, TO, "timeout_write");
  endtask

  task automatic test_misaligned();
    run_txn(0, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h12345678, 0, "word_load_0x101");
    run_txn(1, 1'b0, 2'd1, 1'b0, 32'h203, 32'h0, 32'h8765F00D, 0, "half_load_0x203");
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    req_write = 2'b00;
    req_size  = {2'd2, 2'd2};
    req_signed = 2'b00;
    req_addr  = {32'h0000_0A00, 32'h0000_0B00};
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL arb_grant0: req_ready=%b want 01", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    waitrequest  = 1'b0;
    readdata     = 32'hA5A5_0000;
    #1;
    checks++;
    if (read !== 1'b1 || address !== 32'h0000_0B00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL arb_bus0: read=%b addr=%h ready=%b want 1/00000b00/00", read, address, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hA5A5_0000 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL arb_resp0: rv=%b rdata=%h ready=%b want 01/a5a50000/00", resp_valid, resp_rdata, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arb_grant1: req_ready=%b busy=%b want 10/0", req_ready, busy);
    end
    @(negedge clk);
    req_valid  = 2'b00;
    readdata   = 32'h0000_5A5A;
    #1;
    checks++;
    if (read !== 1'b1 || address !== 32'h0000_0A00) begin
      errors++;
      $display("FAIL arb_bus1: read=%b addr=%h want 1/00000a00", read, address);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 2'b10 || resp_rdata !== 32'h0000_5A5A) begin
      errors++;
      $display("FAIL arb_resp1: rv=%b rdata=%h want 10/00005a5a", resp_valid, resp_rdata);
    end
    @(negedge clk);
    $display("txn arbitration port0 then port1");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int port, waits;
      logic wr, sgn;
      logic [1:0] sz;
      logic [31:0] addr, wd, rd;
      port  = $urandom_range(0, 1);
      wr    = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      addr  = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      waits = ($urandom_range(0, 7) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
      run_txn(port, wr, sz, sgn, addr, wd, rd, waits, "random");
    end
  endtask

  task automatic test_reset_mid_bus();
    @(negedge clk);
    req_write  = 2'b00;
    req_size   = {2'd2, 2'd2};
    req_addr   = {32'h0000_0300, 32'h0};
    req_valid  = 2'b10;
    waitrequest = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++;
    if (read !== 1'b1) begin
      errors++;
      $display("FAIL midbus_read_before_reset: read=%b want 1", read);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (read !== 1'b0 || busy !== 1'b0 || address !== 32'h0 || byteenable !== 4'b0000) begin
      errors++;
      $display("FAIL midbus_reset_abort: read=%b busy=%b addr=%h be=%b want 0/0/0/0", read, busy, address, byteenable);
    end
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midbus_no_resp cycle%0d: rv=%b busy=%b want 00/0", k, resp_valid, busy);
      end
    end
    $display("txn reset mid-bus");
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store_wait();
    test_timeout();
    test_misaligned();
    test_arbitration();
    test_random();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
